instr_prefetch_queue: RTL
=========================

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-002 Parameter ADDR_WIDTH, default 16, instruction address width.
REQ-003 Parameter INSTR_WIDTH, default 28, instruction word width.
REQ-004 Clock  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 iBranchTaken  input  1  redirect request from the execute stage; flushes the queue.
REQ-007 iBranchTarget  input  ADDR_WIDTH  new fetch address, sampled when iBranchTaken=1.
REQ-008 oROMAddress  output  ADDR_WIDTH  address to the combinational instruction ROM; equals the fetch pointer.
REQ-009 iROMData  input  INSTR_WIDTH  ROM word at oROMAddress, same cycle.
REQ-010 oInstruction  output  INSTR_WIDTH  head-of-queue instruction to decode.
REQ-011 oInstrAddr  output  ADDR_WIDTH  address of oInstruction.
REQ-012 oValid  output  1  oInstruction/oInstrAddr are valid.
REQ-013 iReady  input  1  decode accepts head; a pop occurs when oValid=1 and iReady=1.
REQ-014 oCount  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Fetch pointer rFetchIP drives oROMAddress; push occurs when iBranchTaken=0 and (count<DEPTH or a pop occurs that cycle).
REQ-016 Push writes {rFetchIP, iROMData} at the tail and increments rFetchIP by 1, wrapping from all-ones to 0.
REQ-017 Simultaneous push and pop leave count unchanged; push-only increments count, pop-only decrements it.
REQ-018 Full with no pop: no push, rFetchIP held, no entry overwritten.
REQ-019 Empty: oValid=0; a pop is impossible and iReady is ignored.
REQ-020 iBranchTaken=1 has priority over push and pop: on that edge count<=0, head/tail pointers <=0, rFetchIP<=iBranchTarget; the head is not consumed.
REQ-021 Branch latency without bypass: the target instruction is presented with oValid=1 two cycles after the iBranchTaken edge.
REQ-022 Head/tail pointers wrap modulo DEPTH; oCount never exceeds DEPTH.
REQ-023 oInstruction, oInstrAddr, oValid are registered from queue storage (no combinational path from iROMData) unless REQ-030 applies.
REQ-024 Steady-state throughput with iReady held at 1: one instruction per cycle, addresses strictly consecutive.

Reset
REQ-025 Reset asserted at any time, including mid-fill or during a branch, asynchronously forces rFetchIP=0, count=0, pointers=0.
REQ-026 During reset: oValid=0, oCount=0, oROMAddress=0, oInstruction=0, oInstrAddr=0.
REQ-027 After reset release, the first push fetches address 0 on the first rising edge.

Configuration
REQ-028 Macro PREFETCH_BYPASS_EN selects empty-queue bypass.
REQ-029 Without PREFETCH_BYPASS_EN: behaviour exactly per REQ-015..REQ-024.
REQ-030 With PREFETCH_BYPASS_EN, when count=0 and iBranchTaken=0: oValid=1, oInstruction=iROMData, oInstrAddr=rFetchIP.
REQ-031 With PREFETCH_BYPASS_EN, a bypassed instruction that is accepted (iReady=1) is not written to the queue; rFetchIP still increments.
REQ-032 With PREFETCH_BYPASS_EN, branch latency is one cycle.

Structure
REQ-033 A shared package holds the default ADDR_WIDTH/INSTR_WIDTH constants and the instruction-entry struct {address, word}.
REQ-034 Storage is one sub-module, prefetch_queue_mem: DEPTH x (ADDR_WIDTH+INSTR_WIDTH) registers, one write port and one async read port, no reset on data.

Verification
REQ-035 Reset release, iReady=0, ROM word = address -> after 4 edges oCount=4, oROMAddress=4, oInstrAddr=0, oInstruction=0; 5th edge leaves oCount=4.
REQ-036 iReady=1 continuously from reset -> oInstrAddr 0,1,2,3,... on consecutive cycles, with no gaps after the initial latency.
REQ-037 Queue full (addresses 0-3), iBranchTaken=1 and iBranchTarget=0x0040 for one cycle -> next cycle oCount=0, oValid=0; oInstrAddr=0x0040 with oValid=1 two cycles after the branch edge (one with PREFETCH_BYPASS_EN).
REQ-038 rFetchIP loaded to 0xFFFE via branch -> pushed addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-039 Full queue, iReady=1 and push on the same edge -> oCount stays 4, head advances by one, tail receives the next address.
REQ-040 Reset asserted between edges while oCount=3 -> oValid and oCount drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_prefetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_prefetch_queue_pkg
//  Description : Shared constants and types for the instruction prefetch
//                queue: default address/instruction widths and the queue
//                entry layout {address, word}.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_prefetch_queue_pkg;

    localparam int DEFAULT_ADDR_WIDTH  = 16;
    localparam int DEFAULT_INSTR_WIDTH = 28;

    // One queue entry at default widths. The address sits in the upper bits,
    // matching the packing used by the storage array.
    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0]  addr;
        logic [DEFAULT_INSTR_WIDTH-1:0] word;
    } instrEntry_t;

endpackage : instr_prefetch_queue_pkg
`default_nettype wire

// File: rtl/instr_prefetch_queue_mem.sv
`default_nettype none
// ============================================================================
//  Module      : prefetch_queue_mem
//  Description : DEPTH x WIDTH register array for the prefetch queue.
//                One synchronous write port, one asynchronous read port.
//                Data registers carry no reset; validity is tracked by the
//                queue controller.
//  Ports       : clk        - clock
//                iWrEn      - write enable
//                iWrAddr    - write index
//                iWrData    - write data
//                iRdAddr    - read index
//                oRdData    - read data (combinational from the array)
//  Revision    : 1.0 - initial release
// ============================================================================
module prefetch_queue_mem
    import instr_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DEFAULT_ADDR_WIDTH + DEFAULT_INSTR_WIDTH
) (
    input  logic                     clk,
    input  logic                     iWrEn,
    input  logic [$clog2(DEPTH)-1:0] iWrAddr,
    input  logic [WIDTH-1:0]         iWrData,
    input  logic [$clog2(DEPTH)-1:0] iRdAddr,
    output logic [WIDTH-1:0]         oRdData
);

    logic [WIDTH-1:0] rMem [DEPTH];

    always_ff @(posedge clk) begin
        if (iWrEn) begin
            rMem[iWrAddr] <= iWrData;
        end
    end

    assign oRdData = rMem[iRdAddr];

endmodule : prefetch_queue_mem
`default_nettype wire

// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instr_prefetch_queue
//  Description : Instruction prefetch queue. A fetch pointer addresses a
//                combinational ROM; each cycle with room (or a simultaneous
//                pop) the {address, word} pair is pushed and the pointer
//                advances. A taken branch flushes the queue and reloads the
//                fetch pointer.
//  Config      : PREFETCH_BYPASS_EN - when defined, an empty queue presents
//                the ROM word directly to decode (one-cycle branch latency).
//  Ports       : clk           - clock
//                rst           - asynchronous active-high reset
//                iBranchTaken  - flush and redirect
//                iBranchTarget - new fetch address
//                oROMAddress   - ROM address (fetch pointer)
//                iROMData      - ROM word at oROMAddress
//                oInstruction  - head instruction
//                oInstrAddr    - head instruction address
//                oValid        - head is valid
//                iReady        - decode accepts head
//                oCount        - queue occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iBranchTaken,
    input  logic [ADDR_WIDTH-1:0]    iBranchTarget,
    output logic [ADDR_WIDTH-1:0]    oROMAddress,
    input  logic [INSTR_WIDTH-1:0]   iROMData,
    output logic [INSTR_WIDTH-1:0]   oInstruction,
    output logic [ADDR_WIDTH-1:0]    oInstrAddr,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [$clog2(DEPTH):0]   oCount
);

    localparam int cPtrWidth   = $clog2(DEPTH);
    localparam int cCntWidth   = cPtrWidth + 1;
    localparam int cEntryWidth = ADDR_WIDTH + INSTR_WIDTH;

    logic [ADDR_WIDTH-1:0]  rFetchIP;
    logic [cPtrWidth-1:0]   rHead;
    logic [cPtrWidth-1:0]   rTail;
    logic [cCntWidth-1:0]   rCount;

    logic [cEntryWidth-1:0] wHeadEntry;
    logic [ADDR_WIDTH-1:0]  wHeadAddr;
    logic [INSTR_WIDTH-1:0] wHeadWord;
    logic                   wQueueValid;
    logic                   wFull;
    logic                   wPop;
    logic                   wPush;
    logic                   wWrite;

    assign wHeadAddr   = wHeadEntry[cEntryWidth-1:INSTR_WIDTH];
    assign wHeadWord   = wHeadEntry[INSTR_WIDTH-1:0];
    assign wQueueValid = (rCount != '0);
    assign wFull       = (rCount == cCntWidth'(DEPTH));

    // Pop only ever refers to a stored entry; a bypassed word is consumed
    // without touching the head pointer.
    assign wPop  = wQueueValid && iReady;
    // A pop frees a slot on the same edge, so a full queue can still push.
    assign wPush = !iBranchTaken && (!wFull || wPop);

`ifdef PREFETCH_BYPASS_EN
    logic wBypass;
    logic wBypassTake;

    // rst gating keeps the outputs quiet while reset is held.
    assign wBypass     = !wQueueValid && !iBranchTaken && !rst;
    assign wBypassTake = wBypass && iReady;
    // A word accepted straight from the ROM never needs a queue slot.
    assign wWrite      = wPush && !wBypassTake;

    assign oValid       = wQueueValid || wBypass;
    assign oInstruction = wBypass ? iROMData : (wQueueValid ? wHeadWord : '0);
    assign oInstrAddr   = wBypass ? rFetchIP : (wQueueValid ? wHeadAddr : '0);
`else
    assign wWrite = wPush;

    // Outputs come only from stored entries; zeroed when the queue is empty
    // so that uninitialised storage never reaches decode.
    assign oValid       = wQueueValid;
    assign oInstruction = wQueueValid ? wHeadWord : '0;
    assign oInstrAddr   = wQueueValid ? wHeadAddr : '0;
`endif

    assign oROMAddress = rFetchIP;
    assign oCount      = rCount;

    prefetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (cEntryWidth)
    ) uMem (
        .clk     (clk),
        .iWrEn   (wWrite),
        .iWrAddr (rTail),
        .iWrData ({rFetchIP, iROMData}),
        .iRdAddr (rHead),
        .oRdData (wHeadEntry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rFetchIP <= '0;
            rHead    <= '0;
            rTail    <= '0;
            rCount   <= '0;
        end else if (iBranchTaken) begin
            // Redirect wins over any push/pop in the same cycle.
            rFetchIP <= iBranchTarget;
            rHead    <= '0;
            rTail    <= '0;
            rCount   <= '0;
        end else begin
            if (wPush) begin
                rFetchIP <= rFetchIP + ADDR_WIDTH'(1);
            end
            if (wWrite) begin
                rTail <= rTail + cPtrWidth'(1);
            end
            if (wPop) begin
                rHead <= rHead + cPtrWidth'(1);
            end
            case ({wWrite, wPop})
                2'b10:   rCount <= rCount + cCntWidth'(1);
                2'b01:   rCount <= rCount - cCntWidth'(1);
                default: rCount <= rCount;
            endcase
        end
    end

endmodule : instr_prefetch_queue
`default_nettype wire
